// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with a valid/ready handshake on both sides.
// Single-cycle ops register on the accepting edge. The optional iterative
// shift-add multiplier (op 8) is built only when SEQ_ALU_MUL_EN is defined.
// Without that macro, op 8 completes as an illegal opcode and no multiplier
// logic is generated.
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             overflow,
   output logic             negative,
   output logic             illegal
);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SHR = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;

   typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

   state_t           state;
   state_t           state_next;
   logic             accept;
   logic             start_mul;
   logic             mul_done;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;
   logic             alu_ill;
   logic [WIDTH:0]   sum;

`ifdef SEQ_ALU_MUL_EN
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [2*WIDTH-1:0] mul_a;
   logic [WIDTH-1:0]   mul_b;
   logic [2*WIDTH-1:0] mul_acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [CW-1:0]      mul_cnt;

   // A multiply starts only for op 8; the last partial product finishes the op
   assign start_mul = (op == OP_MUL);
   assign mul_done  = (state == MUL) && (mul_cnt == CW'(WIDTH - 1));
   assign acc_next  = mul_acc + (mul_b[0] ? mul_a : '0);
`else
   assign start_mul = 1'b0;
   assign mul_done  = 1'b0;
`endif

   assign out_valid = (state == HOLD);

   // State register; reset aborts whatever operation is in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Handshake and next-state: a new op may be taken while the previous result drains
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      case (state)
         IDLE:    in_ready = 1'b1;
         HOLD:    in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
      accept = in_valid & in_ready;
      case (state)
         IDLE, HOLD: begin
            if (accept) begin
               state_next = start_mul ? MUL : HOLD;
            end else if ((state == HOLD) && out_ready) begin
               state_next = IDLE;
            end
         end
         MUL: begin
            if (mul_done) begin
               state_next = HOLD;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Single-cycle datapath evaluated directly on the presented operands
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_ill = 1'b0;
      sum     = '0;
      case (op)
         OP_ADD: begin
            sum     = {1'b0, a} + {1'b0, b};
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            sum     = {1'b0, a} - {1'b0, b};
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_XOR: alu_res = a ^ b;
         OP_NOT: alu_res = ~a;
         OP_SHL: begin
            alu_res = {a[WIDTH-2:0], 1'b0};
            alu_c   = a[WIDTH-1];
         end
         OP_SHR: begin
            alu_res = {1'b0, a[WIDTH-1:1]};
            alu_c   = a[0];
         end
`ifdef SEQ_ALU_MUL_EN
         OP_MUL: alu_ill = 1'b0;
`endif
         default: alu_ill = 1'b1;
      endcase
   end

   // Result and flag registers, loaded on a single-cycle accept or multiply completion
   always_ff @(posedge clk) begin
      if (rst) begin
         result   <= '0;
         carry    <= 1'b0;
         zero     <= 1'b0;
         overflow <= 1'b0;
         negative <= 1'b0;
         illegal  <= 1'b0;
      end else if (accept && !start_mul) begin
         result   <= alu_res;
         carry    <= alu_c;
         zero     <= (alu_res == '0);
         overflow <= alu_v;
         negative <= alu_res[WIDTH-1];
         illegal  <= alu_ill;
      end
`ifdef SEQ_ALU_MUL_EN
      else if (mul_done) begin
         result   <= acc_next[WIDTH-1:0];
         carry    <= |acc_next[2*WIDTH-1:WIDTH];
         zero     <= (acc_next[WIDTH-1:0] == '0);
         overflow <= 1'b0;
         negative <= acc_next[WIDTH-1];
         illegal  <= 1'b0;
      end
`endif
   end

`ifdef SEQ_ALU_MUL_EN
   // Shift-add multiplier: one partial product per MUL cycle, operands frozen at accept
   always_ff @(posedge clk) begin
      if (rst) begin
         mul_a   <= '0;
         mul_b   <= '0;
         mul_acc <= '0;
         mul_cnt <= '0;
      end else if (accept && start_mul) begin
         mul_a   <= {{WIDTH{1'b0}}, a};
         mul_b   <= b;
         mul_acc <= '0;
         mul_cnt <= '0;
      end else if (state == MUL) begin
         mul_a   <= mul_a << 1;
         mul_b   <= mul_b >> 1;
         mul_acc <= acc_next;
         mul_cnt <= mul_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed table-driven bench for seq_alu at WIDTH=8.
// Honors SEQ_ALU_MUL_EN the same way the design does.
module tb_seq_alu;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [3:0]   op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         carry;
   logic         zero;
   logic         overflow;
   logic         negative;
   logic         illegal;

   int checks = 0;
   int fails  = 0;

   typedef struct {
      string      name;
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       c;
      logic       z;
      logic       v;
      logic       n;
      logic       ill;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry     (carry),
      .zero      (zero),
      .overflow  (overflow),
      .negative  (negative),
      .illegal   (illegal)
   );

   function automatic vec_t mk(string name, logic [3:0] o, logic [7:0] va, logic [7:0] vb,
                               logic [7:0] r, logic c, logic z, logic v, logic n, logic ill);
      vec_t t;
      t.name = name; t.op = o; t.a = va; t.b = vb; t.res = r;
      t.c = c; t.z = z; t.v = v; t.n = n; t.ill = ill;
      return t;
   endfunction

   // Single comparison point: every check goes through here
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Present one op, let it be taken on the next edge, then drop in_valid
   task automatic applyStimulus(input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb);
      op       = o;
      a        = va;
      b        = vb;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   function automatic logic [12:0] pack(logic [7:0] r, logic c, logic z, logic v, logic n, logic ill);
      return {r, c, z, v, n, ill};
   endfunction

   function automatic logic [12:0] dut_bundle();
      return {result, carry, zero, overflow, negative, illegal};
   endfunction

`ifdef SEQ_ALU_MUL_EN
   // Multiply with latency measurement; operands are scrambled after accept
   task automatic checkMul(input string name, input logic [7:0] va, input logic [7:0] vb,
                           input logic [7:0] r, input logic c, input logic z, input logic n);
      int lat;
      applyStimulus(4'h8, va, vb);
      a   = 8'h55;
      b   = 8'hA5;
      op  = 4'h0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         checkOutput({name, "_in_ready_busy"}, 32'(in_ready), 32'd0);
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput({name, "_latency"}, 32'(lat), 32'(W + 1));
      checkOutput({name, "_out_valid"}, 32'(out_valid), 32'd1);
      checkOutput({name, "_bundle"}, 32'(dut_bundle()), 32'(pack(r, c, z, 1'b0, n, 1'b0)));
   endtask
`endif

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op        = 4'h0;
      a         = '0;
      b         = '0;

      vecs.push_back(mk("add_aa_11", 4'h0, 8'hAA, 8'h11, 8'hBB, 0, 0, 0, 1, 0));
      vecs.push_back(mk("add_7f_01", 4'h0, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 1, 0));
      vecs.push_back(mk("add_ff_01", 4'h0, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 0, 0));
      vecs.push_back(mk("sub_05_01", 4'h1, 8'h05, 8'h01, 8'h04, 0, 0, 0, 0, 0));
      vecs.push_back(mk("sub_01_05", 4'h1, 8'h01, 8'h05, 8'hFC, 1, 0, 0, 1, 0));
      vecs.push_back(mk("sub_80_01", 4'h1, 8'h80, 8'h01, 8'h7F, 0, 0, 1, 0, 0));
      vecs.push_back(mk("and_c3_3c", 4'h2, 8'hC3, 8'h3C, 8'h00, 0, 1, 0, 0, 0));
      vecs.push_back(mk("or_81_02",  4'h3, 8'h81, 8'h02, 8'h83, 0, 0, 0, 1, 0));
      vecs.push_back(mk("not_0f",    4'h5, 8'h0F, 8'h00, 8'hF0, 0, 0, 0, 1, 0));
      vecs.push_back(mk("shl_81",    4'h6, 8'h81, 8'h00, 8'h02, 1, 0, 0, 0, 0));
      vecs.push_back(mk("shr_05",    4'h7, 8'h05, 8'h00, 8'h02, 1, 0, 0, 0, 0));
      vecs.push_back(mk("illegal_a", 4'hA, 8'h12, 8'h34, 8'h00, 0, 1, 0, 0, 1));
      vecs.push_back(mk("illegal_f", 4'hF, 8'hFF, 8'hFF, 8'h00, 0, 1, 0, 0, 1));
`ifndef SEQ_ALU_MUL_EN
      vecs.push_back(mk("mul_off",   4'h8, 8'h0F, 8'h0F, 8'h00, 0, 1, 0, 0, 1));
`endif

      // Reset state
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_bundle", 32'(dut_bundle()), 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

      // Table: back-to-back single-cycle ops, each result one cycle after accept
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
         checkOutput({vecs[i].name, "_out_valid"}, 32'(out_valid), 32'd1);
         checkOutput({vecs[i].name, "_in_ready"}, 32'(in_ready), 32'd1);
         checkOutput({vecs[i].name, "_bundle"}, 32'(dut_bundle()),
                     32'(pack(vecs[i].res, vecs[i].c, vecs[i].z, vecs[i].v, vecs[i].n, vecs[i].ill)));
      end
      @(posedge clk);
      #1;
      checkOutput("drain_out_valid", 32'(out_valid), 32'd0);

      // ADD, XOR, AND on consecutive cycles
      applyStimulus(4'h0, 8'h01, 8'h02);
      checkOutput("b2b_add", 32'(dut_bundle()), 32'(pack(8'h03, 0, 0, 0, 0, 0)));
      checkOutput("b2b_add_ready", 32'(in_ready), 32'd1);
      applyStimulus(4'h4, 8'h0F, 8'hFF);
      checkOutput("b2b_xor", 32'(dut_bundle()), 32'(pack(8'hF0, 0, 0, 0, 1, 0)));
      checkOutput("b2b_xor_valid", 32'(out_valid), 32'd1);
      applyStimulus(4'h2, 8'hF0, 8'h3C);
      checkOutput("b2b_and", 32'(dut_bundle()), 32'(pack(8'h30, 0, 0, 0, 0, 0)));
      checkOutput("b2b_and_valid", 32'(out_valid), 32'd1);

      // Consumer stalls for three cycles while a new OR is offered
      out_ready = 1'b0;
      op        = 4'h3;
      a         = 8'h01;
      b         = 8'h02;
      in_valid  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk);
         #1;
         checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
         checkOutput("stall_bundle", 32'(dut_bundle()), 32'(pack(8'h30, 0, 0, 0, 0, 0)));
      end
      out_ready = 1'b1;
      #1;
      checkOutput("unstall_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("unstall_or", 32'(dut_bundle()), 32'(pack(8'h03, 0, 0, 0, 0, 0)));
      checkOutput("unstall_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;

`ifdef SEQ_ALU_MUL_EN
      checkMul("mul_10_20", 8'h10, 8'h20, 8'h00, 1'b1, 1'b1, 1'b0);
      checkMul("mul_0f_0f", 8'h0F, 8'h0F, 8'hE1, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      // Abort a multiply in its fourth cycle
      applyStimulus(4'h8, 8'h10, 8'h20);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
`else
      // Abort an op held in HOLD by a stalled consumer
      out_ready = 1'b0;
      applyStimulus(4'h0, 8'h22, 8'h33);
      checkOutput("hold_before_rst", 32'(out_valid), 32'd1);
      rst = 1'b1;
`endif
      @(posedge clk);
      #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      #1;
      checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
      checkOutput("abort_bundle", 32'(dut_bundle()), 32'd0);
      checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         checkOutput("abort_no_valid", 32'(out_valid), 32'd0);
      end

      // Reset wins over a simultaneous accept
      rst      = 1'b1;
      op       = 4'h0;
      a        = 8'h05;
      b        = 8'h01;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      checkOutput("rst_override_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_override_bundle", 32'(dut_bundle()), 32'd0);

      applyStimulus(4'h0, 8'h05, 8'h01);
      checkOutput("post_rst_add_valid", 32'(out_valid), 32'd1);
      checkOutput("post_rst_add", 32'(dut_bundle()), 32'(pack(8'h06, 0, 0, 0, 0, 0)));

      $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
      $finish;
   end

endmodule
